// File: rtl/lock_pkg.sv
// lock_pkg: definitions shared by the canal-lock pilot and the lock controller.
//   lock_state_e : pilot FSM states with fixed 4-bit LED codes (IDLE=0 .. FAULT=10)
//   Side*        : side select values (outer/inner port and water body)
//   Cmd*         : bit positions of the command vector driven to the lock controller
package lock_pkg;

    typedef enum logic [3:0] {
        StIdle     = 4'd0,
        StEqSrc    = 4'd1,
        StOpenSrc  = 4'd2,
        StArrive   = 4'd3,
        StCloseSrc = 4'd4,
        StEqDst    = 4'd5,
        StOpenDst  = 4'd6,
        StDepart   = 4'd7,
        StCloseDst = 4'd8,
        StAbort    = 4'd9,
        StFault    = 4'd10
    } lock_state_e;

    // The source side equals the latched direction bit, the destination its inverse.
    localparam logic SideOuter = 1'b0;
    localparam logic SideInner = 1'b1;

    localparam int unsigned CmdOuter  = 0;
    localparam int unsigned CmdInner  = 1;
    localparam int unsigned CmdRaise  = 2;
    localparam int unsigned CmdLower  = 3;
    localparam int unsigned CmdArrive = 4;
    localparam int unsigned CmdDepart = 5;
    localparam int unsigned CmdDir    = 6;
    localparam int unsigned NumCmds   = 7;

    // States that make up a normal transit (abort-able).
    function automatic logic is_transit(lock_state_e s);
        return (s >= StEqSrc) && (s <= StCloseDst);
    endfunction

    // Second half of the transit addresses the destination side.
    function automatic logic in_dst_leg(lock_state_e s);
        return (s == StEqDst) || (s == StOpenDst) || (s == StDepart) || (s == StCloseDst);
    endfunction

    // Successor of a transit state on normal completion of its step.
    function automatic lock_state_e next_step(lock_state_e s);
        case (s)
            StEqSrc:    return StOpenSrc;
            StOpenSrc:  return StArrive;
            StArrive:   return StCloseSrc;
            StCloseSrc: return StEqDst;
            StEqDst:    return StOpenDst;
            StOpenDst:  return StDepart;
            StDepart:   return StCloseDst;
            default:    return StIdle;
        endcase
    endfunction

endpackage

// File: rtl/lock_watchdog.sv
// lock_watchdog: per-state stall detector for the lock pilot.
//   clk, reset_n : clock, asynchronous active-low reset
//   restart_i    : high during the first cycle of a newly entered state
//   expired_o    : high once the state has been occupied for TIMEOUT cycles
module lock_watchdog #(
    parameter int unsigned TIMEOUT = 256
) (
    input  logic clk,
    input  logic reset_n,
    input  logic restart_i,
    output logic expired_o
);

    localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    // restart_i arrives one cycle after entry, so one cycle is already used up and the
    // terminal count of zero is reached after TIMEOUT-1 further cycles.
    localparam logic [CntW-1:0] LoadVal = CntW'(TIMEOUT - 2);

    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= LoadVal;
        end else if (restart_i) begin
            cnt_q <= LoadVal;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CntW'(1);
        end
    end

    // The count is stale during the restart cycle.
    assign expired_o = !restart_i && (cnt_q == '0);

endmodule

// File: rtl/lock_pilot.sv
// lock_pilot: automatic operator for the canal-lock controller. A start pulse runs one
// full transit (equalise, open, gondola in, close, equalise, open, gondola out, close).
//   clk, reset_n             : clock, asynchronous active-low reset
//   start_i, dir_out_i       : transit request and direction (1 = inside to outside)
//   abort_i                  : level request for safe shutdown of a transit
//   *_water_i                : water levels of outer side, lock chamber, inner side
//   outer/inner_open_i       : port-open flags; gondola_in_i: gondola inside the lock
//   cmd_*_o                  : level commands to the lock controller, cmd_dir_o direction
//   busy_o, done_o, aborted_o, fault_o, state_o : status for board LEDs
module lock_pilot
    import lock_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned TIMEOUT = 256
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start_i,
    input  logic             dir_out_i,
    input  logic             abort_i,
    input  logic [WIDTH-1:0] outer_water_i,
    input  logic [WIDTH-1:0] lock_water_i,
    input  logic [WIDTH-1:0] inner_water_i,
    input  logic             outer_open_i,
    input  logic             inner_open_i,
    input  logic             gondola_in_i,
    output logic             cmd_outer_o,
    output logic             cmd_inner_o,
    output logic             cmd_raise_o,
    output logic             cmd_lower_o,
    output logic             cmd_arrive_o,
    output logic             cmd_depart_o,
    output logic             cmd_dir_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             aborted_o,
    output logic             fault_o,
    output logic [3:0]       state_o
);

    lock_state_e        state_q, state_d;
    logic [NumCmds-1:0] cmd_q, cmd_d;
    logic               busy_q, done_q, aborted_q, fault_q, restart_q;
    logic               dir_d;
    logic               expired;
    logic               step_exit;
    logic               cur_side, nxt_side, cur_open, ports_closed;
    logic [WIDTH-1:0]   cur_level, nxt_level;

    lock_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .reset_n  (reset_n),
        .restart_i(restart_q),
        .expired_o(expired)
    );

    // Side addressed by the current state (exit test) and by the next state (decode).
    assign cur_side     = cmd_q[CmdDir] ^ in_dst_leg(state_q);
    assign nxt_side     = dir_d ^ in_dst_leg(state_d);
    assign cur_level    = (cur_side == SideInner) ? inner_water_i : outer_water_i;
    assign nxt_level    = (nxt_side == SideInner) ? inner_water_i : outer_water_i;
    assign cur_open     = (cur_side == SideInner) ? inner_open_i : outer_open_i;
    assign ports_closed = !outer_open_i && !inner_open_i;

    always_comb begin
        step_exit = 1'b0;
        case (state_q)
            StEqSrc, StEqDst:       step_exit = (lock_water_i == cur_level);
            StOpenSrc, StOpenDst:   step_exit = cur_open;
            StArrive:               step_exit = gondola_in_i;
            StDepart:               step_exit = !gondola_in_i;
            StCloseSrc, StCloseDst: step_exit = !cur_open;
            default:                step_exit = 1'b0;
        endcase
    end

    // Next state; priority within a transit is abort, then watchdog, then step completion.
    always_comb begin
        state_d = state_q;
        dir_d   = cmd_q[CmdDir];
        if (state_q == StIdle) begin
            if (start_i) begin
                state_d = StEqSrc;
                dir_d   = dir_out_i;
            end
        end else if (state_q == StAbort) begin
            if (expired) begin
                state_d = StFault;
            end else if (ports_closed) begin
                state_d = StIdle;
            end
        end else if (is_transit(state_q)) begin
            if (abort_i) begin
                state_d = StAbort;
            end else if (expired) begin
                state_d = StFault;
            end else if (step_exit) begin
                state_d = next_step(state_q);
            end
        end
    end

    // Commands of the next state, registered so they appear from its first cycle.
    always_comb begin
        cmd_d         = '0;
        cmd_d[CmdDir] = dir_d;
        case (state_d)
            StEqSrc, StEqDst: begin
                // Never move water while any port may still be open.
                if (ports_closed) begin
                    cmd_d[CmdRaise] = (lock_water_i < nxt_level);
                    cmd_d[CmdLower] = (lock_water_i > nxt_level);
                end
            end
            StOpenSrc, StArrive, StOpenDst, StDepart: begin
                cmd_d[CmdOuter] = (nxt_side == SideOuter);
                cmd_d[CmdInner] = (nxt_side == SideInner);
            end
            default: ;
        endcase
        cmd_d[CmdArrive] = (state_d == StArrive);
        cmd_d[CmdDepart] = (state_d == StDepart);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            cmd_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            fault_q   <= 1'b0;
            restart_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            busy_q    <= is_transit(state_d) || (state_d == StAbort);
            done_q    <= (state_q == StCloseDst) && (state_d == StIdle);
            aborted_q <= (state_q == StAbort) && (state_d == StIdle);
            fault_q   <= (state_d == StFault);
            restart_q <= (state_d != state_q);
        end
    end

    assign cmd_outer_o  = cmd_q[CmdOuter];
    assign cmd_inner_o  = cmd_q[CmdInner];
    assign cmd_raise_o  = cmd_q[CmdRaise];
    assign cmd_lower_o  = cmd_q[CmdLower];
    assign cmd_arrive_o = cmd_q[CmdArrive];
    assign cmd_depart_o = cmd_q[CmdDepart];
    assign cmd_dir_o    = cmd_q[CmdDir];
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign aborted_o    = aborted_q;
    assign fault_o      = fault_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_lock_pilot.sv
// tb_lock_pilot: directed bench for lock_pilot with a responsive lock-controller model
// (water moves one step per commanded cycle, ports and gondola follow commands half a
// cycle later) and a transit-level reference model compared on every clock.
module tb_lock_pilot;

    localparam int W  = 8;
    localparam int TO = 32;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic         start_i = 1'b0, dir_out_i = 1'b0, abort_i = 1'b0;
    logic [W-1:0] outer_water = '0, lock_water = '0, inner_water = '0;
    logic         outer_open = 1'b0, inner_open = 1'b0, gondola_in = 1'b0;
    logic         cmd_outer_o, cmd_inner_o, cmd_raise_o, cmd_lower_o;
    logic         cmd_arrive_o, cmd_depart_o, cmd_dir_o;
    logic         busy_o, done_o, aborted_o, fault_o;
    logic [3:0]   state_o;

    lock_pilot #(
        .WIDTH  (W),
        .TIMEOUT(TO)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start_i      (start_i),
        .dir_out_i    (dir_out_i),
        .abort_i      (abort_i),
        .outer_water_i(outer_water),
        .lock_water_i (lock_water),
        .inner_water_i(inner_water),
        .outer_open_i (outer_open),
        .inner_open_i (inner_open),
        .gondola_in_i (gondola_in),
        .cmd_outer_o  (cmd_outer_o),
        .cmd_inner_o  (cmd_inner_o),
        .cmd_raise_o  (cmd_raise_o),
        .cmd_lower_o  (cmd_lower_o),
        .cmd_arrive_o (cmd_arrive_o),
        .cmd_depart_o (cmd_depart_o),
        .cmd_dir_o    (cmd_dir_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .aborted_o    (aborted_o),
        .fault_o      (fault_o),
        .state_o      (state_o)
    );

    int checks = 0;
    int failures = 0;

    // Environment knobs.
    int init_outer = 0, init_lock = 0, init_inner = 0;
    bit stuck_outer = 0, hold_gondola = 0;

    // Reference model: state numbered by position in the transit (0 idle, 1..8 steps,
    // 9 abort, 10 fault), age = cycles spent in it.
    int           m_state = 0, m_age = 0;
    bit           m_dir = 0, m_done = 0, m_aborted = 0;
    logic [14:0]  exp_out;

    // Monitors, only ever incremented.
    int raise_cyc = 0, lower_cyc = 0, done_cnt = 0, eq_src_cyc = 0, eq_dst_cyc = 0;
    int open_src_cyc = 0, dir_low_busy = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s at t=%0t: got 0x%0h, required 0x%0h", name, $time, act, req);
        end
    endtask

    function automatic logic [14:0] dut_pack();
        return {state_o, cmd_outer_o, cmd_inner_o, cmd_raise_o, cmd_lower_o, cmd_arrive_o,
                cmd_depart_o, cmd_dir_o, busy_o, done_o, aborted_o, fault_o};
    endfunction

    // 0 = outer, 1 = inner. First half of the transit works on the source side.
    function automatic bit side_of(int s);
        return (s <= 4) ? m_dir : !m_dir;
    endfunction

    function automatic bit leg_complete(int s);
        bit           sd = side_of(s);
        bit           op = sd ? inner_open : outer_open;
        logic [W-1:0] lv = sd ? inner_water : outer_water;
        case ((s - 1) % 4)
            0:       return lock_water == lv;
            1:       return op;
            2:       return (s == 3) ? gondola_in : !gondola_in;
            default: return !op;
        endcase
    endfunction

    task automatic model_step();
        int           nxt;
        int           kind;
        bit           transit, sd, adj, port_on;
        logic [W-1:0] lv;
        logic [3:0]   st;
        m_done    = 0;
        m_aborted = 0;
        if (!reset_n) begin
            m_state = 0;
            m_age   = 0;
            m_dir   = 0;
        end else begin
            m_age++;
            nxt = m_state;
            if (m_state == 0) begin
                if (start_i) begin
                    nxt   = 1;
                    m_dir = dir_out_i;
                end
            end else if (m_state == 9) begin
                if (m_age >= TO) nxt = 10;
                else if (!outer_open && !inner_open) begin
                    nxt       = 0;
                    m_aborted = 1;
                end
            end else if (m_state != 10) begin
                if (abort_i) nxt = 9;
                else if (m_age >= TO) nxt = 10;
                else if (leg_complete(m_state)) begin
                    if (m_state == 8) begin
                        nxt    = 0;
                        m_done = 1;
                    end else begin
                        nxt = m_state + 1;
                    end
                end
            end
            if (nxt != m_state) m_age = 0;
            m_state = nxt;
        end
        transit = (m_state >= 1) && (m_state <= 8);
        kind    = transit ? (m_state - 1) % 4 : -1;
        sd      = side_of(m_state);
        lv      = sd ? inner_water : outer_water;
        adj     = (kind == 0) && !outer_open && !inner_open;
        port_on = (kind == 1) || (kind == 2);
        st      = 4'(m_state);
        exp_out = {st, port_on && !sd, port_on && sd, adj && (lock_water < lv),
                   adj && (lock_water > lv), m_state == 3, m_state == 7, m_dir,
                   (m_state >= 1) && (m_state <= 9), m_done, m_aborted, m_state == 10};
    endtask

    // One clock: model and compare after the rising edge, controller reacts on the falling.
    task automatic tick();
        bit inv_ok;
        @(posedge clk);
        model_step();
        #1;
        check("outputs", 32'(dut_pack()), 32'(exp_out));
        inv_ok = !(cmd_outer_o && cmd_inner_o) && !(cmd_raise_o && cmd_lower_o) &&
                 !((cmd_raise_o || cmd_lower_o) &&
                   (cmd_outer_o || cmd_inner_o || outer_open || inner_open));
        check("invariant", 32'(inv_ok), 32'd1);
        raise_cyc    += int'(cmd_raise_o);
        lower_cyc    += int'(cmd_lower_o);
        done_cnt     += int'(done_o);
        eq_src_cyc   += int'(state_o == 4'd1);
        eq_dst_cyc   += int'(state_o == 4'd5);
        open_src_cyc += int'(state_o == 4'd2);
        dir_low_busy += int'(busy_o && !cmd_dir_o);
        @(negedge clk);
        if (!reset_n) begin
            outer_water = W'(init_outer);
            lock_water  = W'(init_lock);
            inner_water = W'(init_inner);
            outer_open  = 1'b0;
            inner_open  = 1'b0;
            gondola_in  = 1'b0;
        end else begin
            if (cmd_raise_o) lock_water = lock_water + 1'b1;
            else if (cmd_lower_o) lock_water = lock_water - 1'b1;
            outer_open = cmd_outer_o && !stuck_outer;
            inner_open = cmd_inner_o;
            if (cmd_arrive_o && !hold_gondola) gondola_in = 1'b1;
            else if (cmd_depart_o) gondola_in = 1'b0;
        end
    endtask

    task automatic run_until(input logic [3:0] s, input int budget, input string name);
        int n;
        tick();
        n = 1;
        while (state_o != s && n < budget) begin
            tick();
            n++;
        end
        check(name, 32'(state_o), 32'(s));
    endtask

    task automatic do_reset(input int o, input int l, input int i);
        init_outer = o;
        init_lock  = l;
        init_inner = i;
        reset_n    = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic pulse_start(input logic dir, input logic abt);
        start_i   = 1'b1;
        dir_out_i = dir;
        abort_i   = abt;
        tick();
        start_i = 1'b0;
        abort_i = 1'b0;
    endtask

    initial begin : watchdog_guard
        #300000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin : stimulus
        int r0, l0, d0, e0, e1, o0, b0;

        // Reset state.
        do_reset(20, 5, 10);
        check("reset_outputs", 32'(dut_pack()), 32'd0);

        // Inbound transit, outer=20 lock=5 inner=10.
        r0 = raise_cyc; l0 = lower_cyc; d0 = done_cnt; e0 = eq_src_cyc; e1 = eq_dst_cyc;
        pulse_start(1'b0, 1'b0);
        check("inbound_first_state", 32'(state_o), 32'd1);
        run_until(4'd0, 200, "inbound_reaches_idle");
        check("inbound_done_pulse", 32'(done_o), 32'd1);
        check("inbound_raise_cycles", 32'(raise_cyc - r0), 32'd15);
        check("inbound_lower_cycles", 32'(lower_cyc - l0), 32'd10);
        check("inbound_eq_src_cycles", 32'(eq_src_cyc - e0), 32'd15);
        check("inbound_eq_dst_cycles", 32'(eq_dst_cyc - e1), 32'd10);
        check("inbound_final_lock", 32'(lock_water), 32'd10);
        tick();
        check("inbound_done_one_cycle", 32'(done_o), 32'd0);
        check("inbound_done_count", 32'(done_cnt - d0), 32'd1);

        // Outbound with all levels equal; start and abort together in IDLE.
        do_reset(7, 7, 7);
        r0 = raise_cyc + lower_cyc; d0 = done_cnt; e0 = eq_src_cyc; e1 = eq_dst_cyc;
        b0 = dir_low_busy;
        pulse_start(1'b1, 1'b1);
        check("outbound_started", 32'(state_o), 32'd1);
        check("outbound_dir", 32'(cmd_dir_o), 32'd1);
        run_until(4'd0, 100, "outbound_reaches_idle");
        check("outbound_no_adjust", 32'(raise_cyc + lower_cyc - r0), 32'd0);
        check("outbound_eq_src_1cyc", 32'(eq_src_cyc - e0), 32'd1);
        check("outbound_eq_dst_1cyc", 32'(eq_dst_cyc - e1), 32'd1);
        check("outbound_done", 32'(done_cnt - d0), 32'd1);
        check("outbound_dir_held", 32'(dir_low_busy - b0), 32'd0);

        // Outer port never opens: watchdog fault.
        do_reset(7, 7, 7);
        stuck_outer = 1;
        o0 = open_src_cyc;
        pulse_start(1'b0, 1'b0);
        run_until(4'd10, 100, "fault_reached");
        check("fault_open_src_cycles", 32'(open_src_cyc - o0), 32'(TO));
        check("fault_flag", 32'(fault_o), 32'd1);
        pulse_start(1'b0, 1'b0);
        repeat (3) tick();
        check("fault_sticky", 32'(state_o), 32'd10);
        reset_n = 1'b0;
        #1;
        check("fault_async_clear", 32'(dut_pack()), 32'd0);
        stuck_outer = 0;
        do_reset(7, 7, 7);

        // Abort while the gondola is arriving with the outer port open.
        hold_gondola = 1;
        pulse_start(1'b0, 1'b0);
        run_until(4'd3, 50, "abort_reach_arrive");
        check("abort_port_open", 32'(outer_open), 32'd1);
        abort_i = 1'b1;
        tick();
        check("abort_state", 32'(state_o), 32'd9);
        check("abort_cmds_dropped", 32'({cmd_outer_o, cmd_arrive_o}), 32'd0);
        check("abort_not_yet", 32'(aborted_o), 32'd0);
        tick();
        check("abort_pulse", 32'({state_o, aborted_o}), 32'h01);
        abort_i = 1'b0;
        hold_gondola = 0;
        tick();
        check("abort_pulse_one_cycle", 32'(aborted_o), 32'd0);
        pulse_start(1'b0, 1'b0);
        check("restart_after_abort", 32'(state_o), 32'd1);
        run_until(4'd0, 100, "restart_completes");

        // Starts while busy are ignored; reset in the middle of EQ_DST.
        do_reset(20, 5, 10);
        pulse_start(1'b0, 1'b0);
        repeat (4) begin
            pulse_start(1'b1, 1'b0);
            tick();
        end
        check("busy_start_ignored", 32'({state_o, cmd_dir_o}), 32'h02);
        run_until(4'd5, 100, "reach_eq_dst");
        repeat (3) tick();
        check("mid_eq_dst_lowering", 32'(cmd_lower_o), 32'd1);
        reset_n = 1'b0;
        #1;
        check("async_reset_clear", 32'(dut_pack()), 32'd0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        check("idle_after_reset", 32'(dut_pack()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", checks, failures);
        $finish;
    end

endmodule
